// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int DEFAULT_TMO = 64;

  function automatic logic op_legal(input logic [2:0] instr);
    return (instr[2:1] == OP_MUL) || (instr[2:1] == OP_DIV) || (instr[2:1] == OP_ADD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search begins one past the pointer and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  always_comb begin
    int unsigned cand;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(ptr) + i) % unsigned'(NREQ);
      if (!found && req[IW'(cand)]) begin
        found            = 1'b1;
        grant[IW'(cand)] = 1'b1;
        grant_idx        = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Multi-requester scheduler in front of a shared fixed-point ALU, with
// round-robin arbitration, operation timeout and illegal-opcode trapping.
module alu_sched
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int Q    = 16,
  parameter int NREQ = 4,
  parameter int TMO  = DEFAULT_TMO
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][2:0]      req_instr,
  input  logic [NREQ-1:0][N-1:0]    req_a,
  input  logic [NREQ-1:0][N-1:0]    req_b,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [N-1:0]              rsp_data,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic                      enable_alu,
  output logic [2:0]                alu_instr,
  output logic [N-1:0]              alu_a,
  output logic [N-1:0]              alu_b,
  input  logic                      alu_valid,
  input  logic                      alu_zero,
  input  logic [N-1:0]              alu_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  if (Q >= N || NREQ < 2 || NREQ > 8) begin : g_cfg_check
    $error("alu_sched: unsupported parameter combination");
  end

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] grant;
  logic [CW-1:0]   tmo_cnt;
  logic            hs;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Ready is combinational so the winner is accepted in the same cycle it is chosen.
  always_comb begin
    req_ready = '0;
    if (rstn && state == IDLE) req_ready = grant;
    hs = |(req_valid & req_ready);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NREQ - 1);
      owner      <= '0;
      tmo_cnt    <= '0;
      enable_alu <= 1'b0;
      alu_instr  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (hs) begin
            rr_ptr    <= gidx;
            owner     <= gidx;
            alu_instr <= req_instr[gidx];
            alu_a     <= req_a[gidx];
            alu_b     <= req_b[gidx];
            tmo_cnt   <= '0;
            if (op_legal(req_instr[gidx])) begin
              state      <= ISSUE;
              enable_alu <= 1'b1;
            end else begin
              state     <= RESP;
              rsp_valid <= NREQ'(1) << gidx;
              rsp_data  <= '0;
              rsp_zero  <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // alu_valid is checked first so it wins over a simultaneous timeout.
          if (alu_valid) begin
            state      <= RESP;
            enable_alu <= 1'b0;
            rsp_valid  <= NREQ'(1) << owner;
            rsp_data   <= alu_data;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end else if (tmo_cnt == CW'(TMO)) begin
            state      <= RESP;
            enable_alu <= 1'b0;
            rsp_valid  <= NREQ'(1) << owner;
            rsp_data   <= '0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          enable_alu <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a latency-programmable ALU stub.
module tb_alu_sched;

  localparam int N    = 32;
  localparam int Q    = 16;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][2:0]   req_instr;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [N-1:0]           rsp_data;
  logic                   rsp_zero;
  logic                   rsp_err;
  logic                   enable_alu;
  logic [2:0]             alu_instr;
  logic [N-1:0]           alu_a;
  logic [N-1:0]           alu_b;
  logic                   alu_valid;
  logic                   alu_zero;
  logic [N-1:0]           alu_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int stub_lat   = 1;
  bit stub_never = 1'b0;
  bit spur       = 1'b0;
  int en_cnt     = 0;

  alu_sched #(.N(N), .Q(Q), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_instr  (req_instr),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .enable_alu (enable_alu),
    .alu_instr  (alu_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_valid  (alu_valid),
    .alu_zero   (alu_zero),
    .alu_data   (alu_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: result after stub_lat cycles of enable (or never)
  always @(posedge clk) en_cnt <= enable_alu ? en_cnt + 1 : 0;

  always_comb begin
    longint sa, sb;
    sa = longint'($signed(alu_a));
    sb = longint'($signed(alu_b));
    case (alu_instr[2:1])
      2'b10:   alu_data = alu_a + alu_b;
      2'b00:   alu_data = N'((sa * sb) >>> Q);
      2'b01:   alu_data = (sb != 0) ? N'((sa <<< Q) / sb) : '0;
      default: alu_data = '0;
    endcase
    alu_zero  = (alu_data == '0);
    alu_valid = spur | (enable_alu && !stub_never && (en_cnt == stub_lat - 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference: fixed-point result of a legal op, as plain arithmetic.
  function automatic logic [N-1:0] model_res(input logic [2:0] ins, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    longint x, y;
    x = $signed(a);
    y = $signed(b);
    if (ins[2:1] == 2'b10) return N'(x + y);
    if (ins[2:1] == 2'b00) return N'((x * y) / 65536 - (((x * y) % 65536 < 0) ? 1 : 0));
    return N'((x * 65536) / y);
  endfunction

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rspv"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp"}, {rsp_data, rsp_zero, rsp_err}, 64'(0));
    chk({tag, "_alu"}, {enable_alu, alu_instr, alu_a}, 64'(0));
    chk({tag, "_alub"}, 64'(alu_b), 64'(0));
  endtask

  typedef struct {
    int          idx;
    logic [2:0]  instr;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    bit          never;
    logic [31:0] exp_data;
    bit          exp_zero;
    bit          exp_err;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  task automatic run_vec(input vec_t v, input int num);
    int  h, ens;
    bit  got, seen_en;
    string tag;
    tag = $sformatf("vec%0d", num);
    @(negedge clk);
    stub_lat            = v.lat;
    stub_never          = v.never;
    req_valid           = '0;
    req_valid[v.idx]    = 1'b1;
    req_instr[v.idx]    = v.instr;
    req_a[v.idx]        = v.a;
    req_b[v.idx]        = v.b;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(onehot(v.idx)));
    h = cyc;
    @(negedge clk);
    req_valid = '0;
    ens = 0; got = 1'b0; seen_en = 1'b0;
    for (int k = 0; k < TMO + 10; k++) begin
      #1;
      if (enable_alu) begin
        ens++;
        if (!seen_en) begin
          seen_en = 1'b1;
          chk({tag, "_aluop"}, {alu_instr, alu_a, alu_b}, {v.instr, v.a, v.b});
        end
      end
      if (rsp_valid != '0) begin
        got = 1'b1;
        chk({tag, "_lat"}, 64'(cyc - h), 64'(v.exp_lat));
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'(onehot(v.idx)));
        chk({tag, "_rsp"}, {rsp_data, rsp_zero, rsp_err}, {v.exp_data, v.exp_zero, v.exp_err});
        chk({tag, "_en"}, 64'(ens), 64'(v.exp_en));
        break;
      end
      @(negedge clk);
    end
    if (!got) chk({tag, "_timeout"}, 64'(0), 64'(1));
    @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    int grants[$];
    int gcyc[$];
    req_valid = '0;
    req_instr = '0;
    req_a     = '0;
    req_b     = '0;
    rstn      = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // four requesters holding add ops: grants rotate 0,1,2,3,0 every 3 cycles
    stub_lat = 1; stub_never = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_instr[i] = 3'b100;
      req_a[i]     = 32'(i);
      req_b[i]     = 32'h1;
    end
    req_valid = '1;
    for (int k = 0; k < 30 && grants.size() < 5; k++) begin
      #1;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin
          grants.push_back(i);
          gcyc.push_back(cyc);
        end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_count", 64'(grants.size()), 64'(5));
    for (int i = 0; i < grants.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % NREQ));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(3));
    end
    repeat (3) @(negedge clk);

    vecs[0] = '{0, 3'b100, 32'h0001_8000, 32'h0002_4000, 1, 0, 32'h0003_C000, 0, 0, 2, 1};
    vecs[1] = '{2, 3'b000, 32'h0002_0000, 32'h0003_0000, 5, 0, 32'h0006_0000, 0, 0, 6, 5};
    vecs[2] = '{1, 3'b010, 32'h0006_0000, 32'h0002_0000, 1, 1, 32'h0, 1, 1, TMO + 2, TMO + 1};
    vecs[3] = '{3, 3'b110, 32'h1234_5678, 32'h1, 1, 0, 32'h0, 1, 1, 1, 0};
    vecs[4] = '{0, 3'b101, 32'h0000_8000, 32'hFFFF_8000, 1, 0, 32'h0, 1, 0, 2, 1};
    vecs[5] = '{1, 3'b011, 32'h0006_0000, 32'h0002_0000, 3, 0, 32'h0003_0000, 0, 0, 4, 3};
    vecs[6] = '{2, 3'b001, 32'hFFFF_0000, 32'h0002_8000, TMO + 1, 0, 32'hFFFD_8000, 0, 0, TMO + 2, TMO + 1};
    vecs[7] = '{3, 3'b111, 32'h0, 32'h0, 1, 0, 32'h0, 1, 1, 1, 0};
    vecs[8] = '{0, 3'b000, 32'h0001_0000, 32'h0001_0000, 1, 0, 32'h0001_0000, 0, 0, 2, 1};
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset on the third ISSUE cycle of a multiply
    @(negedge clk);
    stub_lat = 10; stub_never = 1'b0;
    req_valid = 4'b0100; req_instr[2] = 3'b000;
    req_a[2] = 32'h0002_0000; req_b[2] = 32'h0003_0000;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_en", 64'(enable_alu), 64'(1));
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      spur = (k == 1);
      @(negedge clk);
      #1;
      chk($sformatf("quiet%0d", k), {enable_alu, rsp_valid}, 64'(0));
    end
    spur = 1'b0;
    stub_lat = 1;
    req_instr[0] = 3'b100; req_instr[3] = 3'b100;
    req_valid = 4'b1001;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // randomized traffic against the reference model
    do_reset();
    begin
      int last = NREQ - 1;
      bit busy = 1'b0;
      int owner = 0, exp_cyc = 0, en_from = 0, en_to = -1, drop = -1;
      logic [N-1:0] exp_d;
      bit exp_z, exp_e;
      logic [NREQ-1:0] exp_ready;
      for (int t = 0; t < 400; t++) begin
        if (drop >= 0) req_valid[drop] = 1'b0;
        drop = -1;
        for (int i = 0; i < NREQ; i++)
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_instr[i] = 3'($urandom_range(0, 7));
            req_a[i]     = $urandom;
            req_b[i]     = $urandom;
            if (req_b[i] == '0) req_b[i] = 32'h1;
          end
        #1;
        exp_ready = '0;
        if (!busy)
          for (int k = 1; k <= NREQ; k++)
            if (req_valid[(last + k) % NREQ]) begin
              exp_ready[(last + k) % NREQ] = 1'b1;
              break;
            end
        chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
        chk("rnd_en", 64'(enable_alu), 64'(busy && cyc >= en_from && cyc <= en_to));
        if (busy && cyc == exp_cyc) begin
          chk("rnd_rspv", 64'(rsp_valid), 64'(onehot(owner)));
          chk("rnd_rsp", {rsp_data, rsp_zero, rsp_err}, {exp_d, exp_z, exp_e});
          busy = 1'b0;
        end else begin
          chk("rnd_norsp", 64'(rsp_valid), 64'(0));
        end
        if (exp_ready != '0) begin
          for (int i = 0; i < NREQ; i++) if (exp_ready[i]) owner = i;
          last = owner; drop = owner; busy = 1'b1;
          en_from = cyc + 1;
          if (req_instr[owner][2:1] == 2'b11) begin
            exp_cyc = cyc + 1; en_to = cyc;
            exp_d = '0; exp_z = 1'b1; exp_e = 1'b1;
          end else begin
            stub_never = (req_instr[owner][2:1] != 2'b10) && ($urandom_range(0, 7) == 0);
            stub_lat   = (req_instr[owner][2:1] == 2'b10) ? 1 : $urandom_range(1, 6);
            if (stub_never) begin
              exp_cyc = cyc + TMO + 2;
              exp_d = '0; exp_z = 1'b1; exp_e = 1'b1;
            end else begin
              exp_cyc = cyc + 1 + stub_lat;
              exp_d = model_res(req_instr[owner], req_a[owner], req_b[owner]);
              exp_z = (exp_d == '0); exp_e = 1'b0;
            end
            en_to = exp_cyc - 1;
          end
        end
        @(negedge clk);
      end
    end
    req_valid = '0;
    repeat (TMO + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
